tdt_dmi_arb: RTL
================

Name: tdt_dmi_arb

Overview:
- Two-requester DMI arbiter and APB master that shares one Debug Module register bus between the JTAG DTM (requester 0) and a second debug port (requester 1).
- Latches each requester's single-cycle request pulse and grants round-robin.
- Runs the APB SETUP/ACCESS sequence, enforces a PREADY timeout, and returns a one-cycle ready pulse with read data and error status to the granted requester.

Parameters:
- DTM_ABITS, 16, DMI address width.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles before abort (8-bit counter; must be 1..255).

Ports:
- tclk  input  1  clock.
- trst_b  input  1  reset, synchronous, active-low.
- reqN_vld  input  1  single-cycle request pulse (N = 0, 1; same set for each requester).
- reqN_addr  input  DTM_ABITS  request address.
- reqN_flg  input  2  op: 01 = read, 10 = write.
- reqN_wdata  input  32  write data.
- reqN_ready  output  1  single-cycle completion pulse.
- reqN_rdata  output  32  read data; valid with reqN_ready.
- reqN_err  output  1  slave error or timeout; valid with reqN_ready.
- paddr  output  DTM_ABITS  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB write.
- pwdata  output  32  APB write data.
- prdata  input  32  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB error.

Behaviour:
- Reset: all of the following are cleared when trst_b is low at the tclk edge. Asserting reset mid-transaction drops psel the following cycle and produces no response pulse.
  - FSM = IDLE.
  - Pending flags = 0.
  - last_grant = 1, so requester 0 wins first.
  - Timeout counter = 0.
  - Every output = 0.
- Request latch, one per requester:
  - reqN_vld with flg 01 or 10 sets pendN and captures addr/flg/wdata.
  - A vld with flg 00 or 11 is ignored: no latch, no response.
  - A vld while pendN is already set is dropped and the captured fields keep their original values.
  - If a new vld arrives in the same cycle the RESP state clears pendN, the set wins and the new fields are captured.
- FSM states and transitions:
  - IDLE: if exactly one pend is set, grant that requester. If both are set, grant the requester not equal to last_grant. Go to SETUP.
  - SETUP: psel=1, penable=0. paddr/pwrite/pwdata come from the granted latch (pwrite = flg==10). Lasts exactly one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1, counter increments each cycle.
    - pready=1: capture prdata and pslverr, go to RESP.
    - counter == TIMEOUT_CYCLES with pready=0: abort. Set captured err=1 and rdata=0, go to RESP.
    - pready wins if it arrives in the same cycle as the timeout.
  - RESP: psel=0, penable=0. The granted reqN_ready pulses 1 for one cycle with the captured rdata and err. rdata is forwarded for writes too; the requester filters by op. Clear the granted pend, set last_grant = granted, clear the counter, go to IDLE.
- All outputs are registered. APB outputs hold stable throughout SETUP and ACCESS.
- rdata/err hold their last values between ready pulses.
- The non-granted reqN_ready is always 0.
- Latency with a zero-wait slave: vld at cycle 0 → pend at 1 → SETUP at 2 → ACCESS at 3 (pready seen) → reqN_ready at 4. Minimum 4 cycles per transaction and a 4-cycle back-to-back issue interval.
- A pending requester waits at most one other transaction (round-robin fairness).

Decomposition:
- Package tdt_dmi_arb_pkg holds:
  - FSM state encoding (IDLE, SETUP, ACCESS, RESP; 2 bits).
  - Op constants DMI_OP_READ = 2'b01 and DMI_OP_WRITE = 2'b10.
  - Requester index constants.
- Sub-module tdt_dmi_arb_req_latch, instantiated twice: holds pend, addr, flg and wdata, with a set-over-clear input.

Test Plan:
- Single read: req0 read addr 0x0011, prdata 0x12345678, pready on the first ACCESS cycle → req0_ready at cycle 4, req0_rdata=0x12345678, err=0, req1_ready stays 0.
- Simultaneous: req0 write addr 0x0010 wdata 0xA5A5A5A5 and req1 read addr 0x0004 issued in the same cycle → the req0 APB write goes first (pwrite=1), then req1. Two ready pulses, 4 cycles apart.
- Fairness: keep both requesters re-requesting immediately after each ready, for 8 transactions → grants alternate 0, 1, 0, 1…
- Errors:
  - pslverr=1 with pready → reqN_err=1.
  - pready held 0 with TIMEOUT_CYCLES=4 → abort after 4 ACCESS cycles, err=1, rdata=0, psel drops in RESP.
- Ignore/drop: flg=00 or 11 pulse → no psel ever. A second vld while pending with new addr 0x0020 → the original address is still used on paddr.
- Reset mid-ACCESS: trst_b low during ACCESS → next cycle psel=0 and pends clear; no ready pulse; after release, the first request is served normally.

Source files
------------

// File: rtl/tdt_dmi_arb_pkg.sv
// rtl/tdt_dmi_arb_pkg.sv - shared types and constants for the DMI arbiter
package tdt_dmi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic op_valid(input logic [1:0] flg);
    return (flg == DMI_OP_READ) || (flg == DMI_OP_WRITE);
  endfunction

endpackage

// File: rtl/tdt_dmi_arb_req_latch.sv
// rtl/tdt_dmi_arb_req_latch.sv - holds one requester's pending DMI op
// A new valid op wins over the completion clear in the same cycle.
module tdt_dmi_arb_req_latch
  import tdt_dmi_arb_pkg::*;
#(
  parameter int DTM_ABITS = 16
) (
  input  logic                 clk,
  input  logic                 trst_b,
  input  logic                 vld,
  input  logic [DTM_ABITS-1:0] req_addr,
  input  logic [1:0]           req_flg,
  input  logic [31:0]          req_wdata,
  input  logic                 clr,
  output logic                 pend,
  output logic [DTM_ABITS-1:0] addr,
  output logic [1:0]           flg,
  output logic [31:0]          wdata
);

  logic take;

  // Requests arriving while already pending are dropped unless the slot frees now.
  assign take = vld && op_valid(req_flg) && (!pend || clr);

  always_ff @(posedge clk) begin
    if (!trst_b) begin
      pend  <= 1'b0;
      addr  <= '0;
      flg   <= '0;
      wdata <= '0;
    end else if (take) begin
      pend  <= 1'b1;
      addr  <= req_addr;
      flg   <= req_flg;
      wdata <= req_wdata;
    end else if (clr) begin
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/tdt_dmi_arb.sv
// rtl/tdt_dmi_arb.sv - two-requester round-robin DMI arbiter and APB master
// Outputs are registered from next-state decode so they align with the state register.
module tdt_dmi_arb
  import tdt_dmi_arb_pkg::*;
#(
  parameter int DTM_ABITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 tclk,
  input  logic                 trst_b,
  input  logic                 req0_vld,
  input  logic [DTM_ABITS-1:0] req0_addr,
  input  logic [1:0]           req0_flg,
  input  logic [31:0]          req0_wdata,
  output logic                 req0_ready,
  output logic [31:0]          req0_rdata,
  output logic                 req0_err,
  input  logic                 req1_vld,
  input  logic [DTM_ABITS-1:0] req1_addr,
  input  logic [1:0]           req1_flg,
  input  logic [31:0]          req1_wdata,
  output logic                 req1_ready,
  output logic [31:0]          req1_rdata,
  output logic                 req1_err,
  output logic [DTM_ABITS-1:0] paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  state_t state, next_state;
  logic   gnt, gnt_next, last_grant;
  logic [7:0] cnt;
  logic   timeout;

  logic [1:0]           pend, clr;
  logic [DTM_ABITS-1:0] lat_addr  [2];
  logic [1:0]           lat_flg   [2];
  logic [31:0]          lat_wdata [2];

  logic                 psel_d, penable_d, pwrite_d, rsp_d, err_d;
  logic [DTM_ABITS-1:0] paddr_d;
  logic [31:0]          pwdata_d, rdata_d;

  assign clr[0]  = (state == ST_RESP) && (gnt == REQ0);
  assign clr[1]  = (state == ST_RESP) && (gnt == REQ1);
  assign timeout = (cnt == 8'(TIMEOUT_CYCLES));

  tdt_dmi_arb_req_latch #(.DTM_ABITS(DTM_ABITS)) u_latch0 (
    .clk(tclk), .trst_b(trst_b), .vld(req0_vld), .req_addr(req0_addr),
    .req_flg(req0_flg), .req_wdata(req0_wdata), .clr(clr[0]), .pend(pend[0]),
    .addr(lat_addr[0]), .flg(lat_flg[0]), .wdata(lat_wdata[0])
  );

  tdt_dmi_arb_req_latch #(.DTM_ABITS(DTM_ABITS)) u_latch1 (
    .clk(tclk), .trst_b(trst_b), .vld(req1_vld), .req_addr(req1_addr),
    .req_flg(req1_flg), .req_wdata(req1_wdata), .clr(clr[1]), .pend(pend[1]),
    .addr(lat_addr[1]), .flg(lat_flg[1]), .wdata(lat_wdata[1])
  );

  always_ff @(posedge tclk) begin
    if (!trst_b) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    gnt_next   = gnt;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          next_state = ST_SETUP;
          gnt_next   = (&pend) ? ~last_grant : pend[1];
        end
      end
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: if (pready || timeout) next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_d    = (next_state == ST_SETUP) || (next_state == ST_ACCESS);
    penable_d = (next_state == ST_ACCESS);
    paddr_d   = paddr;
    pwrite_d  = pwrite;
    pwdata_d  = pwdata;
    if ((state == ST_IDLE) && (next_state == ST_SETUP)) begin
      paddr_d  = lat_addr[gnt_next];
      pwrite_d = (lat_flg[gnt_next] == DMI_OP_WRITE);
      pwdata_d = lat_wdata[gnt_next];
    end
    rsp_d   = (state == ST_ACCESS) && (next_state == ST_RESP);
    // A timeout abort reports zero data with error; a late pready still wins.
    rdata_d = pready ? prdata : 32'h0;
    err_d   = pready ? pslverr : 1'b1;
  end

  always_ff @(posedge tclk) begin
    if (!trst_b) begin
      gnt        <= REQ0;
      last_grant <= REQ1;
      cnt        <= '0;
      paddr      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      gnt <= gnt_next;
      if (state == ST_RESP) begin
        last_grant <= gnt;
        cnt        <= '0;
      end else if (next_state == ST_ACCESS) begin
        cnt <= cnt + 8'd1;
      end
      paddr      <= paddr_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      pwdata     <= pwdata_d;
      req0_ready <= rsp_d && (gnt == REQ0);
      req1_ready <= rsp_d && (gnt == REQ1);
      if (rsp_d && (gnt == REQ0)) begin
        req0_rdata <= rdata_d;
        req0_err   <= err_d;
      end
      if (rsp_d && (gnt == REQ1)) begin
        req1_rdata <= rdata_d;
        req1_err   <= err_d;
      end
    end
  end

endmodule
